alu_issue_sched: RTL and testbench
==================================

// Module: alu_issue_sched
// PURPOSE
//  Shares the single-cycle combinational ALU between two requesters (0: decode/execute, 1: address/aux unit).
//  Round-robin grant; ARM condition check against the architectural NZCV register; result/flags registered
//  and returned over a valid/ready response channel. Owns the NZCV register and feeds ALU current_flags.
// PARAMETERS
//  WIDTH       32       operand/result width
//  FLAG_RST    4'b0000  reset value of NZCV register, ordered {N,Z,C,V}
// PORTS
//  clk              in   1      single clock, rising edge
//  rst_n            in   1      asynchronous, active-low reset
//  reqN_valid       in   1      N=0,1: request present
//  reqN_ready       out  1      N=0,1: request accepted this cycle when valid&ready
//  reqN_cond        in   4      N=0,1: ARM condition field (EQ=0000 ... AL=1110, 1111=never)
//  reqN_cmd         in   8      N=0,1: ALU ctrl_cmd; bit0 = S (flag update enable)
//  reqN_a, reqN_b   in   WIDTH  N=0,1: src1/src2 operands
//  alu_src1/2       out  WIDTH  to ALU src1/src2
//  alu_ctrl_cmd     out  8      to ALU ctrl_cmd
//  alu_cur_flags    out  4      to ALU current_flags (= flags)
//  alu_rd_out       in   WIDTH  from ALU result
//  alu_new_flags    in   4      from ALU new_flags
//  rsp_valid        out  1      response present
//  rsp_ready        in   1      consumer accepts response
//  rsp_id           out  1      requester index of response
//  rsp_result       out  WIDTH  captured ALU result (0 if not executed)
//  rsp_exec         out  1      1 = condition passed and op executed
//  flags            out  4      architectural NZCV
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, flags=FLAG_RST, rr_last=1 (req0 wins first tie), rsp_valid=0,
//   rsp_id=0, rsp_result=0, rsp_exec=0, reqN_ready=0, alu_src*/alu_ctrl_cmd driven 0. In-flight op discarded.
//  States: IDLE -> ISSUE -> RESP -> (IDLE | ISSUE).
//  Accept window: state==IDLE, or state==RESP && rsp_ready. Outside it both reqN_ready=0.
//  Arbitration (combinational, in accept window): one valid -> grant it; both valid -> grant !rr_last.
//   Only granted requester sees ready=1. On accept: latch cond/cmd/a/b/id, rr_last<=id, go ISSUE.
//  ISSUE (1 cycle): alu_* driven from latched op (zeros in other states). Condition evaluated on flags reg:
//   EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V,
//   GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
//   End of ISSUE: rsp_result<=pass?alu_rd_out:0; rsp_exec<=pass; rsp_id<=id; rsp_valid<=1;
//   flags<=alu_new_flags iff pass && cmd[0]; else flags unchanged. Go RESP.
//  RESP: outputs held stable while rsp_valid && !rsp_ready. On rsp_ready: rsp_valid<=0 unless a new
//   request is accepted the same cycle (-> ISSUE, rsp_valid drops next cycle, new rsp 1 cycle later).
//  Latency: accept at T -> ALU driven T+1 -> rsp_valid at T+2. Max throughput 1 op / 2 cycles.
//  Dependent ops: flags written end of ISSUE are seen by the next op's ISSUE (no hazard).
//  Requests dropped by requester before acceptance are legal; latched op unaffected by later input changes.
//  Backpressure: rsp_ready=0 stalls indefinitely in RESP; no request accepted, flags frozen.
// TESTING
//  1 Reset: rst_n=0 mid-ISSUE -> rsp_valid=0, flags=0000, state IDLE immediately (async), no response issued.
//  2 Single op: req0 a=194 b=204 cmd ADD S=1 cond=AL -> rsp at T+2, rsp_result=398, rsp_exec=1, flags=0000.
//  3 Flags/cond: req0 SUB S=1 a=5 b=5 -> Z=1,C=1; then req1 cond=NE -> rsp_exec=0, result=0, flags stay 0110.
//  4 Contention: req0 and req1 valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1, one rsp per 2 cycles.
//  5 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, both ready=0; release -> next op accepted same cycle.
//  6 S=0 op with cond=AL and ALU new_flags=1111 -> flags unchanged, rsp_exec=1; cond=1111 -> rsp_exec=0.

Source files
------------

// File: rtl/alu_issue_sched.sv
// Shares one combinational ALU between two requesters: round-robin issue, ARM
// condition check against the owned NZCV register, registered valid/ready response.
module alu_issue_sched #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_cond,
  input  logic [7:0]       req0_cmd,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_cond,
  input  logic [7:0]       req1_cmd,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [7:0]       alu_ctrl_cmd,
  output logic [3:0]       alu_cur_flags,
  input  logic [WIDTH-1:0] alu_rd_out,
  input  logic [3:0]       alu_new_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_exec,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state, state_nxt;
  logic             rr_last;
  logic [3:0]       cond_p1;
  logic [7:0]       cmd_p1;
  logic [WIDTH-1:0] a_p1, b_p1;
  logic             id_p1;
  logic             accept_win, gnt_id, accept, pass;

  // Flags are ordered {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cy;
      4'h3:    return !cy;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cy && !z;
      4'h9:    return !cy || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // A new op may be taken while idle, or while the pending response is being consumed.
  always_comb begin
    accept_win = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
    gnt_id     = (req0_valid && req1_valid) ? !rr_last : req1_valid;
    accept     = accept_win && (req0_valid || req1_valid);
    req0_ready = accept && !gnt_id;
    req1_ready = accept && gnt_id;
    pass       = cond_pass(cond_p1, flags);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_src1      = '0;
    alu_src2      = '0;
    alu_ctrl_cmd  = '0;
    alu_cur_flags = flags;
    if (state == ISSUE) begin
      alu_src1     = a_p1;
      alu_src2     = b_p1;
      alu_ctrl_cmd = cmd_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage p1: operand capture on accept; no reset needed, only consumed in ISSUE.
  always_ff @(posedge clk) begin
    if (accept) begin
      cond_p1 <= gnt_id ? req1_cond : req0_cond;
      cmd_p1  <= gnt_id ? req1_cmd  : req0_cmd;
      a_p1    <= gnt_id ? req1_a    : req0_a;
      b_p1    <= gnt_id ? req1_b    : req0_b;
      id_p1   <= gnt_id;
    end
  end

  // Stage p2: response and architectural flags, written at the end of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last    <= 1'b1;
      flags      <= FLAG_RST;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_exec   <= 1'b0;
    end else begin
      if (accept) rr_last <= gnt_id;
      if (state == ISSUE) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= id_p1;
        rsp_exec   <= pass;
        rsp_result <= pass ? alu_rd_out : '0;
        if (pass && cmd_p1[0]) flags <= alu_new_flags;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Scoreboard bench for alu_issue_sched with a behavioural ALU attached to the
// alu_* ports; expected responses are queued at acceptance and checked at handshake.
module tb_alu_issue_sched;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_cond = '0, req1_cond = '0;
  logic [7:0]   req0_cmd = '0, req1_cmd = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [W-1:0] alu_src1, alu_src2, alu_rd_out;
  logic [7:0]   alu_ctrl_cmd;
  logic [3:0]   alu_cur_flags, alu_new_flags;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_exec;
  logic [W-1:0] rsp_result;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  alu_issue_sched #(.WIDTH(W), .FLAG_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cond(req0_cond),
    .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cond(req1_cond),
    .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl_cmd(alu_ctrl_cmd),
    .alu_cur_flags(alu_cur_flags), .alu_rd_out(alu_rd_out), .alu_new_flags(alu_new_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_exec(rsp_exec), .flags(flags)
  );

  typedef struct { logic [3:0] cond; logic [7:0] cmd; logic [W-1:0] a, b; } req_t;
  typedef struct { logic id; logic [W-1:0] res; logic ex; logic [3:0] fl; int acc_cyc;
                   logic [W-1:0] a, b; logic [7:0] cmd; } exp_t;

  req_t q0[$], q1[$];
  exp_t sbq[$];
  int   acc_log[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  logic [3:0] mflags = 4'b0000;
  logic mrr = 1'b1, acc0 = 1'b0, acc1 = 1'b0, prev_rv = 1'b0;
  logic eid, p;
  logic [W+3:0] al;
  req_t r, r0, r1;
  exp_t e;
  logic [7:0] cmd_tab [6] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

  // ALU command encoding used by this bench: cmd[7:1] 1=ADD 2=SUB 3=force flags 1111.
  function automatic logic [W+3:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [7:0] cmd);
    logic [W-1:0] rr;
    logic c, v;
    rr = '0; c = 1'b0; v = 1'b0;
    case (cmd[7:1])
      7'd1: begin
        {c, rr} = {1'b0, a} + {1'b0, b};
        v = (a[W-1] == b[W-1]) && (rr[W-1] != a[W-1]);
      end
      7'd2: begin
        {c, rr} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        v = (a[W-1] != b[W-1]) && (rr[W-1] != a[W-1]);
      end
      7'd3: return {4'b1111, a};
      default: ;
    endcase
    return {rr[W-1], (rr == '0), c, v, rr};
  endfunction

  function automatic logic cpass(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] & ~f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  always_comb {alu_new_flags, alu_rd_out} = alu_f(alu_src1, alu_src2, alu_ctrl_cmd);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_req(input int id, input logic [3:0] c, input logic [7:0] cm,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    req_t t;
    t.cond = c; t.cmd = cm; t.a = a; t.b = b;
    if (id == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid &&
          sbq.size() == 0 && !rsp_valid) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  always @(posedge clk) cyc++;

  // Requester drivers: hold a request until it is accepted, then present the next one.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end else begin
      if (acc0 || !req0_valid) begin
        if (q0.size() > 0) begin
          r0 = q0.pop_front();
          req0_valid = 1'b1; req0_cond = r0.cond; req0_cmd = r0.cmd; req0_a = r0.a; req0_b = r0.b;
        end else req0_valid = 1'b0;
      end
      if (acc1 || !req1_valid) begin
        if (q1.size() > 0) begin
          r1 = q1.pop_front();
          req1_valid = 1'b1; req1_cond = r1.cond; req1_cmd = r1.cmd; req1_a = r1.a; req1_b = r1.b;
        end else req1_valid = 1'b0;
      end
    end
  end

  // Monitor: response handshake, issue-cycle ALU drive, arbitration and acceptance.
  always @(negedge clk) begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (rsp_valid && !prev_rv) begin
        if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("latency", cyc - sbq[0].acc_cyc, 2);
      end
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) chk("rsp_orphan", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_exec", rsp_exec, e.ex);
          chk("rsp_flags", flags, e.fl);
        end
      end
      if (sbq.size() > 0 && sbq[$].acc_cyc + 1 == cyc) begin
        chk("alu_src1", alu_src1, sbq[$].a);
        chk("alu_src2", alu_src2, sbq[$].b);
        chk("alu_cmd", alu_ctrl_cmd, sbq[$].cmd);
      end
      if (req0_ready || req1_ready) begin
        eid = (req0_valid && req1_valid) ? !mrr : req1_valid;
        chk("grant", {req1_ready, req0_ready}, eid ? 2'b10 : 2'b01);
        if (eid) begin r.cond = req1_cond; r.cmd = req1_cmd; r.a = req1_a; r.b = req1_b; end
        else     begin r.cond = req0_cond; r.cmd = req0_cmd; r.a = req0_a; r.b = req0_b; end
        p  = cpass(r.cond, mflags);
        al = alu_f(r.a, r.b, r.cmd);
        if (p && r.cmd[0]) mflags = al[W+3:W];
        e.id = eid; e.ex = p; e.res = p ? al[W-1:0] : '0; e.fl = mflags;
        e.acc_cyc = cyc; e.a = r.a; e.b = r.b; e.cmd = r.cmd;
        sbq.push_back(e);
        acc_log.push_back(cyc);
        mrr = eid;
        acc0 = !eid;
        acc1 = eid;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_exec", rsp_exec, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_alu_cmd", alu_ctrl_cmd, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single ADD with flag update.
    push_req(0, 4'hE, 8'h03, 32'd194, 32'd204);
    wait_idle();
    chk("t2_result", rsp_result, 32'd398);
    chk("t2_flags", flags, 4'b0000);

    // SUB sets Z and C, then a NE op from requester 1 is suppressed.
    push_req(0, 4'hE, 8'h05, 32'd5, 32'd5);
    wait_idle();
    chk("t3_flags_sub", flags, 4'b0110);
    push_req(1, 4'h1, 8'h03, 32'd1, 32'd2);
    wait_idle();
    chk("t3_exec", rsp_exec, 0);
    chk("t3_result", rsp_result, 0);
    chk("t3_flags_kept", flags, 4'b0110);

    // Asynchronous reset while an op is in ISSUE.
    push_req(0, 4'hE, 8'h03, 32'd7, 32'd9);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (sbq.size() > 0) break;
    end
    chk("t1_accepted", sbq.size(), 1);
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete(); q1.delete(); sbq.delete();
    mflags = 4'b0000; mrr = 1'b1;
    #1;
    chk("t1_rsp_valid", rsp_valid, 0);
    chk("t1_flags", flags, 4'b0000);
    chk("t1_alu_idle", alu_ctrl_cmd, 0);
    chk("t1_ready", {req1_ready, req0_ready}, 2'b00);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_no_rsp", rsp_valid, 0);
    end

    // S=0 ops leave flags alone; cond 1111 never executes; S=1 force writes 1111.
    push_req(0, 4'hE, 8'h06, 32'h55, 32'h0);
    wait_idle();
    chk("t6_exec", rsp_exec, 1);
    chk("t6_flags", flags, 4'b0000);
    push_req(0, 4'hF, 8'h06, 32'h66, 32'h0);
    wait_idle();
    chk("t6_never", rsp_exec, 0);
    push_req(0, 4'hE, 8'h07, 32'h77, 32'h0);
    push_req(1, 4'hA, 8'h03, 32'd3, 32'd4);
    push_req(1, 4'hB, 8'h03, 32'd3, 32'd4);
    push_req(0, 4'h8, 8'h03, 32'd1, 32'd1);
    wait_idle();

    // Mixed conditions and commands.
    for (int i = 0; i < 10; i++)
      push_req($urandom_range(0, 1), 4'($urandom_range(0, 15)), cmd_tab[$urandom_range(0, 5)],
               $urandom, (i % 3 == 0) ? 32'h0 : $urandom);
    wait_idle();

    // Contention: both requesters always valid, accepts every second cycle.
    acc_log.delete();
    for (int i = 0; i < 4; i++) begin
      push_req(0, 4'hE, 8'h03, $urandom, $urandom);
      push_req(1, 4'hE, 8'h05, $urandom, $urandom);
    end
    wait_idle();
    chk("t4_count", acc_log.size(), 8);
    for (int i = 0; i + 1 < acc_log.size(); i++)
      chk("t4_spacing", acc_log[i+1] - acc_log[i], 2);

    // Backpressure: response held and requests blocked until rsp_ready returns.
    @(posedge clk); #1 rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_req(0, 4'hE, 8'h03, $urandom, $urandom);
      push_req(1, 4'hE, 8'h05, $urandom, $urandom);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) break;
    end
    chk("t5_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_result", rsp_result, sbq[0].res);
      chk("t5_hold_id", rsp_id, sbq[0].id);
      chk("t5_hold_flags", flags, sbq[0].fl);
      chk("t5_blocked", {req1_ready, req0_ready}, 2'b00);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("t5_release_accept", req0_ready | req1_ready, 1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
